fpga_100hz_timer: RTL and testbench



---
 rtl/fpga_100hz_timer.sv | 153 +++++++++++++++
 tb/tb_fpga_100hz_timer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_100hz_timer.sv
// fpga_100hz_timer: 100Hz reference tick counter with reloadable countdown IRQ on APB.
// Optional stale-reference detector enabled by defining FPGA_100HZ_TIMER_STALE_DET_EN.
module fpga_100hz_timer #(
    parameter int SYNC_STAGES = 2,
    parameter int TICK_W      = 32,
    parameter int STALE_LIMIT = 300000
) (
    input  logic        clk25mhz,
    input  logic        reset_n,
    input  logic        clk100hz,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [2:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        tick,
    output logic        irq
);

    localparam logic [2:0] A_CTRL    = 3'd0;
    localparam logic [2:0] A_TICKS   = 3'd1;
    localparam logic [2:0] A_RELOAD  = 3'd2;
    localparam logic [2:0] A_CURRENT = 3'd3;
    localparam logic [2:0] A_INTSTAT = 3'd4;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || STALE_LIMIT < 1)
    begin : g_bad_cfg
        $error("fpga_100hz_timer: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_ff;
    logic [SYNC_STAGES-1:0] fill;
    logic                   sync_out;
    logic                   hist;
    logic                   armed;
    logic                   rise;

    assign sync_out = sync_ff[SYNC_STAGES-1];

    // fill marks when sync_out holds a real sample; armed needs a real low first
    always_ff @(posedge clk25mhz) begin
        if (!reset_n) begin
            sync_ff <= '0;
            fill    <= '0;
            hist    <= 1'b0;
            armed   <= 1'b0;
            rise    <= 1'b0;
            tick    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], clk100hz};
            fill    <= {fill[SYNC_STAGES-2:0], 1'b1};
            hist    <= sync_out;
            armed   <= armed | (fill[SYNC_STAGES-1] & ~sync_out);
            rise    <= armed & sync_out & ~hist;
            tick    <= rise;
        end
    end

    logic              wr_en;
    logic              wr_ctrl;
    logic              wr_ticks;
    logic              wr_reload;
    logic              wr_intstat;
    logic              ctrl_en;
    logic              ctrl_irqen;
    logic [TICK_W-1:0] ticks;
    logic [TICK_W-1:0] reload;
    logic [TICK_W-1:0] current;
    logic              pend;
    logic              pend_set;
    logic              stale;
    logic              step;

    assign wr_en      = psel & penable & pwrite;
    assign wr_ctrl    = wr_en & (paddr == A_CTRL);
    assign wr_ticks   = wr_en & (paddr == A_TICKS);
    assign wr_reload  = wr_en & (paddr == A_RELOAD);
    assign wr_intstat = wr_en & (paddr == A_INTSTAT);
    assign step       = ctrl_en & tick;
    assign pend_set   = step & ~wr_reload & (current == '0);

    always_ff @(posedge clk25mhz) begin
        if (!reset_n) begin
            ctrl_en    <= 1'b0;
            ctrl_irqen <= 1'b0;
            ticks      <= '0;
            reload     <= '0;
            current    <= '0;
            pend       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en    <= pwdata[0];
                ctrl_irqen <= pwdata[1];
            end
            if (wr_ticks)
                ticks <= '0;
            else if (step)
                ticks <= ticks + TICK_W'(1);
            if (wr_reload) begin
                reload  <= pwdata[TICK_W-1:0];
                current <= pwdata[TICK_W-1:0];
            end else if (step) begin
                if (current == '0)
                    current <= reload;
                else
                    current <= current - TICK_W'(1);
            end
            pend <= pend_set | (pend & ~(wr_intstat & pwdata[0]));
        end
    end

`ifdef FPGA_100HZ_TIMER_STALE_DET_EN
    localparam int             SCW  = $clog2(STALE_LIMIT + 1);
    localparam logic [SCW-1:0] SLIM = SCW'(STALE_LIMIT);

    logic [SCW-1:0] stale_cnt;
    logic           stale_hit;

    // hit stays high while saturated, so a clear only sticks after a tick
    assign stale_hit = ~tick & (stale_cnt >= SLIM - SCW'(1));

    always_ff @(posedge clk25mhz) begin
        if (!reset_n) begin
            stale_cnt <= '0;
            stale     <= 1'b0;
        end else begin
            if (tick)
                stale_cnt <= '0;
            else if (stale_cnt != SLIM)
                stale_cnt <= stale_cnt + SCW'(1);
            stale <= stale_hit | (stale & ~(wr_intstat & pwdata[1]));
        end
    end
`else
    assign stale = 1'b0;
`endif

    assign irq = ctrl_irqen & (pend | stale);

    always_comb begin
        prdata = '0;
        case (paddr)
            A_CTRL:    prdata = {30'd0, ctrl_irqen, ctrl_en};
            A_TICKS:   prdata = 32'(ticks);
            A_RELOAD:  prdata = 32'(reload);
            A_CURRENT: prdata = 32'(current);
            A_INTSTAT: prdata = {30'd0, stale, pend};
            default:   prdata = '0;
        endcase
    end

endmodule

// File: tb/tb_fpga_100hz_timer.sv
// tb_fpga_100hz_timer: table vectors, directed corner sequences and
// randomized traffic against a sample-history reference model.
module tb_fpga_100hz_timer;

    localparam int SLIM = 100;

    logic        clk25mhz = 1'b0;
    logic        reset_n  = 1'b0;
    logic        clk100hz = 1'b0;
    logic        psel     = 1'b0;
    logic        penable  = 1'b0;
    logic        pwrite   = 1'b0;
    logic [2:0]  paddr    = 3'd0;
    logic [31:0] pwdata   = 32'd0;
    logic [31:0] prdata;
    logic        tick;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;

    fpga_100hz_timer #(
        .SYNC_STAGES(2),
        .TICK_W     (32),
        .STALE_LIMIT(SLIM)
    ) dut (
        .clk25mhz(clk25mhz),
        .reset_n (reset_n),
        .clk100hz(clk100hz),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .tick    (tick),
        .irq     (irq)
    );

    always #20 clk25mhz = ~clk25mhz;

    // reference model: clk100hz value seen at every clock edge
    bit          samp[$];
    int          n_edge   = -1;
    int          last_rst = 0;
    bit          m_tick, m_en, m_irqen, m_pend, m_stale;
    logic [31:0] m_ticks, m_reload, m_current;
`ifdef FPGA_100HZ_TIMER_STALE_DET_EN
    int          m_scnt;
`endif

    bit gen_on   = 1'b0;
    bit gen_rand = 1'b0;
    int gen_ph   = 0;
    int hi_len   = 10;
    int lo_len   = 10;

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {30'd0, m_irqen, m_en};
            3'd1:    return m_ticks;
            3'd2:    return m_reload;
            3'd3:    return m_current;
            3'd4:    return {30'd0, m_stale, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // tick at edge n: high sample 3 edges back after a low, both after reset
    task automatic model_edge();
        bit wr, tk, step, set;
        int n;
        samp.push_back(clk100hz);
        n_edge++;
        n = n_edge;
        if (!reset_n) begin
            m_tick = 0; m_en = 0; m_irqen = 0; m_pend = 0; m_stale = 0;
            m_ticks = 0; m_reload = 0; m_current = 0;
`ifdef FPGA_100HZ_TIMER_STALE_DET_EN
            m_scnt = 0;
`endif
            last_rst = n;
            return;
        end
        tk   = m_tick;
        wr   = psel && penable && pwrite;
        step = m_en && tk;
        set  = 0;
        if (wr && paddr == 3'd1) m_ticks = 32'd0;
        else if (step) m_ticks = m_ticks + 32'd1;
        if (wr && paddr == 3'd2) begin
            m_reload  = pwdata;
            m_current = pwdata;
        end else if (step) begin
            if (m_current == 32'd0) begin
                m_current = m_reload;
                set = 1;
            end else begin
                m_current = m_current - 32'd1;
            end
        end
        m_pend = set || (m_pend && !(wr && paddr == 3'd4 && pwdata[0]));
`ifdef FPGA_100HZ_TIMER_STALE_DET_EN
        if (tk) m_scnt = 0;
        else if (m_scnt < SLIM) m_scnt++;
        m_stale = (m_scnt == SLIM) ||
                  (m_stale && !(wr && paddr == 3'd4 && pwdata[1]));
`endif
        if (wr && paddr == 3'd0) begin
            m_en    = pwdata[0];
            m_irqen = pwdata[1];
        end
        m_tick = (n >= 4) && samp[n-3] && !samp[n-4] && (n - 4 > last_rst);
    endtask

    task automatic cycle();
        if (gen_on) begin
            clk100hz = (gen_ph < hi_len);
            gen_ph++;
            if (gen_ph >= hi_len + lo_len) begin
                gen_ph = 0;
                if (gen_rand) begin
                    hi_len = $urandom_range(1, 12);
                    lo_len = $urandom_range(1, 12);
                end
            end
        end
        model_edge();
        @(posedge clk25mhz);
        #1;
        check("tick", tick, m_tick);
        check("irq", irq, m_irqen && (m_pend || m_stale));
        check("prdata", prdata, m_read(paddr));
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp,
                      input string name);
        paddr = a;
        #1;
        check(name, prdata, exp);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        psel = 1; penable = 1; pwrite = 1; paddr = a; pwdata = d;
        #1;
        check("pre_write_prdata", prdata, m_read(a));
        cycle();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic wait_tick(input string name);
        int k = 0;
        do begin
            cycle();
            k++;
        end while (!m_tick && k < 200);
        if (!m_tick) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no tick within 200 cycles", name);
        end
    endtask

    initial begin
        tbl[0]  = '{1, 3'd0, 32'hFFFF_FFFF, 32'h3,    "ctrl_mask"};
        tbl[1]  = '{1, 3'd0, 32'h0,         32'h0,    "ctrl_clear"};
        tbl[2]  = '{1, 3'd2, 32'h1234,      32'h1234, "reload_wr"};
        tbl[3]  = '{0, 3'd3, 32'h0,         32'h1234, "reload_to_cur"};
        tbl[4]  = '{1, 3'd3, 32'h5,         32'h1234, "current_ro"};
        tbl[5]  = '{1, 3'd1, 32'hDEAD,      32'h0,    "ticks_wr_clr"};
        tbl[6]  = '{1, 3'd5, 32'hFFFF_FFFF, 32'h0,    "addr5"};
        tbl[7]  = '{0, 3'd6, 32'h0,         32'h0,    "addr6"};
        tbl[8]  = '{0, 3'd7, 32'h0,         32'h0,    "addr7"};
        tbl[9]  = '{1, 3'd4, 32'h3,         32'h0,    "intstat_w1c"};
        tbl[10] = '{1, 3'd2, 32'h0,         32'h0,    "reload_zero"};
        tbl[11] = '{0, 3'd3, 32'h0,         32'h0,    "cur_zero"};

        repeat (3) cycle();
        reset_n = 1;
        for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, "reset_reg");
        check("reset_tick", tick, 0);
        check("reset_irq", irq, 0);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
            rd(tbl[i].addr, tbl[i].exp, tbl[i].name);
        end

        // first sampled high at c=5, tick expected 3 edges later
        for (int c = 0; c < 66; c++) begin
            clk100hz = (c >= 5) && ((c - 5) % 20 < 10);
            cycle();
            check("edge_tick", tick, (c == 8 || c == 28 || c == 48));
        end

        bus_write(3'd0, 32'd1);
        gen_ph = 0; gen_on = 1;
        repeat (140) cycle();
        gen_on = 0; clk100hz = 0;
        repeat (6) cycle();
        rd(3'd1, 32'd7, "ticks_count7");
        gen_ph = 0; gen_on = 1;
        wait_tick("ticks_same");
        bus_write(3'd1, 32'h55);
        rd(3'd1, 32'd0, "ticks_write_wins");
        gen_on = 0; clk100hz = 0;
        repeat (8) cycle();

        bus_write(3'd2, 32'd3);
        bus_write(3'd4, 32'd1);
        bus_write(3'd0, 32'd3);
        gen_ph = 0; gen_on = 1;
        repeat (3) wait_tick("cd");
        cycle();
        check("cd_irq_3rd", irq, 0);
        wait_tick("cd");
        cycle();
        check("cd_irq_4th", irq, 1);
        bus_write(3'd4, 32'd1);
        check("cd_irq_clr", irq, 0);
        repeat (3) wait_tick("cd");
        cycle();
        check("cd_irq_7th", irq, 0);
        wait_tick("cd");
        cycle();
        check("cd_irq_8th", irq, 1);
        bus_write(3'd4, 32'd1);
        check("cd_irq_clr2", irq, 0);
        repeat (4) wait_tick("cd");
        bus_write(3'd4, 32'd1);
        check("set_beats_clr", irq, 1);
        rd(3'd4, 32'd1, "intstat_set_wins");

        wait_tick("wrap");
        cycle();
        force dut.ticks = 32'hFFFF_FFFF;
        m_ticks = 32'hFFFF_FFFF;
        #1 release dut.ticks;
        wait_tick("wrap");
        cycle();
        rd(3'd1, 32'd0, "ticks_wrap");
        rd(3'd3, m_read(3'd3), "wrap_current");
        rd(3'd0, 32'd3, "wrap_ctrl");
        gen_on = 0; clk100hz = 0;
        repeat (8) cycle();

        bus_write(3'd0, 32'd0);
        bus_write(3'd2, 32'd2);
        clk100hz = 1;
        repeat (10) cycle();
        rd(3'd3, 32'd2, "cur_before_rst");
        reset_n = 0;
        cycle();
        reset_n = 1;
        for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, "midrst_reg");
        check("midrst_irq", irq, 0);
        for (int k = 0; k < 20; k++) begin
            cycle();
            check("midrst_no_tick", tick, 0);
        end
        clk100hz = 0;
        repeat (6) cycle();
        for (int k = 0; k < 10; k++) begin
            clk100hz = 1;
            cycle();
            check("midrst_fresh_tick", tick, (k == 3));
        end

        clk100hz = 0;
        repeat (4) cycle();
        bus_write(3'd4, 32'd3);
        bus_write(3'd0, 32'd2);
        paddr = 3'd4;
        for (int k = 0; k < 120; k++) begin
            clk100hz = (k < 5);
            cycle();
            if (k == 103) check("stale_early", prdata, 32'd0);
            if (k == 104) begin
`ifdef FPGA_100HZ_TIMER_STALE_DET_EN
                check("stale_intstat", prdata, 32'd2);
                check("stale_irq", irq, 1);
`else
                check("stale_intstat", prdata, 32'd0);
                check("stale_irq", irq, 0);
`endif
            end
        end

        gen_rand = 1; gen_ph = 0; gen_on = 1;
        for (int i = 0; i < 3000; i++) begin
            psel    = ($urandom_range(0, 3) != 0);
            penable = $urandom_range(0, 1) != 0;
            pwrite  = $urandom_range(0, 1) != 0;
            paddr   = 3'($urandom_range(0, 7));
            pwdata  = (paddr == 3'd2) ? 32'($urandom_range(0, 6))
                                      : $urandom;
            reset_n = ($urandom_range(0, 499) != 0);
            cycle();
        end
        reset_n = 1; psel = 0; penable = 0; pwrite = 0;
        gen_on = 0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
